// File: rtl/nand_page_seq.sv
// NAND page sequencer: one page read or program per op, with optional status poll.
// Flash bus outputs are decoded combinationally from registered state, so reset takes effect at once.
module nand_page_seq #(
    parameter int PAGE_BYTES = 512,
    parameter int TWB_CYC    = 2,
    parameter int RB_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic       op_type,
    input  logic [8:0] op_page,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       status_fail,
    output logic       timeout,
    inout  wire  [7:0] F_IO,
    output logic       F_CLE,
    output logic       F_ALE,
    output logic       F_REN,
    output logic       F_WEN,
    input  logic       F_RB
);
    localparam int WCW = $clog2(RB_TIMEOUT + 1);
    localparam logic [WCW-1:0] TO_LAST = WCW'(RB_TIMEOUT - 1);
    localparam logic [WCW-1:0] TWB     = WCW'(TWB_CYC);
    localparam logic [9:0]     LAST    = 10'(PAGE_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, CMD1, ADDR, WAIT_RB, RDATA, PDATA, CMD2, WAIT_RB2, STAT_CMD, STAT_RD, FIN
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     ph_q, ph_d;
    logic [9:0]     cnt_q, cnt_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           type_q, type_d;
    logic [8:0]     page_q, page_d;
    logic [7:0]     dat_q, dat_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           fail_q, fail_d;
    logic           to_q, to_d;
    logic           io_oe;
    logic [7:0]     io_out;

    assign F_IO        = io_oe ? io_out : 8'bz;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign status_fail = fail_q;
    assign timeout     = to_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ph_q       <= '0;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            type_q     <= 1'b0;
            page_q     <= '0;
            dat_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            fail_q     <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            type_q     <= type_d;
            page_q     <= page_d;
            dat_q      <= dat_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            fail_q     <= fail_d;
            to_q       <= to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        type_d     = type_q;
        page_d     = page_q;
        dat_d      = dat_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        fail_d     = fail_q;
        to_d       = to_q;
        op_ready   = 1'b0;
        wr_ready   = 1'b0;
        done       = 1'b0;
        F_CLE      = 1'b0;
        F_ALE      = 1'b0;
        F_REN      = 1'b1;
        F_WEN      = 1'b1;
        io_oe      = 1'b0;
        io_out     = 8'h00;

        case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    type_d  = op_type;
                    page_d  = op_page;
                    fail_d  = 1'b0;
                    to_d    = 1'b0;
                    ph_d    = '0;
                    cnt_d   = '0;
                    state_d = CMD1;
                end
            end
            CMD1, CMD2, STAT_CMD: begin
                // Fixed-byte command write: WEN low on ph 0, high on ph 1.
                F_CLE  = 1'b1;
                io_oe  = 1'b1;
                io_out = (state_q == CMD2) ? 8'h10 : (state_q == STAT_CMD) ? 8'h70 :
                         (type_q ? 8'h80 : 8'h00);
                F_WEN  = ph_q[0];
                ph_d   = ph_q[0] ? 2'd0 : 2'd1;
                if (ph_q[0]) begin
                    cnt_d  = '0;
                    wcnt_d = '0;
                    state_d = (state_q == CMD1) ? ADDR : (state_q == CMD2) ? WAIT_RB2 : STAT_RD;
                end
            end
            ADDR: begin
                F_ALE  = 1'b1;
                io_oe  = 1'b1;
                io_out = (cnt_q == 10'd0) ? 8'h00 :
                         (cnt_q == 10'd1) ? page_q[7:0] : {7'b0, page_q[8]};
                F_WEN  = ph_q[0];
                ph_d   = ph_q[0] ? 2'd0 : 2'd1;
                if (ph_q[0]) begin
                    if (cnt_q == 10'd2) begin
                        cnt_d   = '0;
                        wcnt_d  = '0;
                        state_d = type_q ? PDATA : WAIT_RB;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            WAIT_RB, WAIT_RB2: begin
                // F_RB is ignored during the first TWB_CYC cycles (tWB).
                if (wcnt_q >= TWB && F_RB) begin
                    ph_d    = '0;
                    cnt_d   = '0;
                    state_d = (state_q == WAIT_RB) ? RDATA : STAT_CMD;
                end else if (wcnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    state_d = FIN;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            RDATA, STAT_RD: begin
                F_REN = (ph_q == 2'd2);
                if (ph_q == 2'd1) begin
                    if (state_q == RDATA) begin
                        rd_data_d  = F_IO;
                        rd_valid_d = 1'b1;
                    end else begin
                        fail_d = F_IO[0];
                    end
                end
                if (ph_q == 2'd2) begin
                    ph_d = '0;
                    if (state_q == STAT_RD) begin
                        state_d = FIN;
                    end else if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = FIN;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end else begin
                    ph_d = ph_q + 2'd1;
                end
            end
            PDATA: begin
                if (ph_q[0] == 1'b0) begin
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        io_oe  = 1'b1;
                        io_out = wr_data;
                        F_WEN  = 1'b0;
                        dat_d  = wr_data;
                        ph_d   = 2'd1;
                    end
                end else begin
                    io_oe  = 1'b1;
                    io_out = dat_q;
                    ph_d   = 2'd0;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = CMD2;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
